// File: rtl/seq_scan_if.sv
// Handshake and detector-side signals of the word-scan controller.
// slave: controller side; master: register side plus detector model.
interface seq_scan_if #(
    parameter int WORD_W = 16,
    parameter int POS_W  = 4,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [WORD_W-1:0] word_in;
    logic              clr_mode;
    logic              det_hit;
    logic              det_in;
    logic              det_rst_n;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  hit_cnt;
    logic              hit_any;
    logic [POS_W-1:0]  first_pos;

    modport slave (
        input  start, word_in, clr_mode, det_hit,
        output det_in, det_rst_n, busy, done,
        output hit_cnt, hit_any, first_pos
    );

    modport master (
        output start, word_in, clr_mode, det_hit,
        input  det_in, det_rst_n, busy, done,
        input  hit_cnt, hit_any, first_pos
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Feeds a latched word MSB-first into the 1110010 detector and
// collects hit count, first hit position and a done pulse.
module seq_scan_ctrl #(
    parameter int WORD_W = 16,
    parameter int POS_W  = 4,
    parameter int CNT_W  = 8
) (
    input logic       clk,
    input logic       rst,
    seq_scan_if.slave bus
);
    localparam int BI_W  = $clog2(WORD_W + 1);
    localparam int IDX_W = (BI_W > POS_W) ? BI_W : POS_W;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WORD_W-1:0] sreg_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [IDX_W-1:0]  prev_idx;
    logic [CNT_W-1:0]  hit_cnt_q;
    logic              hit_any_q;
    logic [POS_W-1:0]  first_pos_q;
    logic              det_rst_n_q;
    logic              accept;
    logic              hit_ok;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = bus.clr_mode ? CLR : SHIFT;
                end
            end
            CLR:   state_d = SHIFT;
            SHIFT: begin
                if (bit_idx_q == IDX_W'(WORD_W - 1))
                    state_d = DRAIN;
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // det_hit lags det_in by one cycle, so it belongs to bit_idx-1
    assign hit_ok = bus.det_hit &&
                    ((state_q == SHIFT && bit_idx_q != '0) ||
                     state_q == DRAIN);
    assign prev_idx = bit_idx_q - IDX_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            bit_idx_q   <= '0;
            hit_cnt_q   <= '0;
            hit_any_q   <= 1'b0;
            first_pos_q <= '0;
            det_rst_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            det_rst_n_q <= (state_d != CLR);
            if (accept) begin
                sreg_q      <= bus.word_in;
                bit_idx_q   <= '0;
                hit_cnt_q   <= '0;
                hit_any_q   <= 1'b0;
                first_pos_q <= '0;
            end else begin
                if (state_q == SHIFT) begin
                    sreg_q    <= {sreg_q[WORD_W-2:0], 1'b0};
                    bit_idx_q <= bit_idx_q + IDX_W'(1);
                end
                if (hit_ok) begin
                    if (hit_cnt_q != '1)
                        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                    if (!hit_any_q) begin
                        hit_any_q   <= 1'b1;
                        first_pos_q <= prev_idx[POS_W-1:0];
                    end
                end
            end
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.det_in    = (state_q == SHIFT) && sreg_q[WORD_W-1];
    assign bus.det_rst_n = det_rst_n_q;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.hit_any   = hit_any_q;
    assign bus.first_pos = first_pos_q;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: detector models, frame-level reference
// model with per-cycle compare, directed and random frames.
module tb_seq_scan_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] PAT = 7'b1110010;

    seq_scan_if #(.WORD_W(16), .POS_W(4), .CNT_W(8)) ia ();
    seq_scan_if #(.WORD_W(32), .POS_W(5), .CNT_W(1)) ib ();

    seq_scan_ctrl #(.WORD_W(16), .POS_W(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .bus(ia)
    );
    seq_scan_ctrl #(.WORD_W(32), .POS_W(5), .CNT_W(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ib)
    );

    // Moore detectors: out high while the last 7 bits equal the pattern
    logic [6:0] hist_a, hist_b;
    always @(posedge clk or negedge rst or negedge ia.det_rst_n)
        if (!rst || !ia.det_rst_n) hist_a <= '0;
        else hist_a <= {hist_a[5:0], ia.det_in};
    always @(posedge clk or negedge rst or negedge ib.det_rst_n)
        if (!rst || !ib.det_rst_n) hist_b <= '0;
        else hist_b <= {hist_b[5:0], ib.det_in};
    assign ia.det_hit = (hist_a == PAT);
    assign ib.det_hit = (hist_b == PAT);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Hits are windows ending on a frame bit; pre is detector history
    function automatic void frame_ref(input logic [63:0] w, input int n,
                                      input logic [6:0] pre, input int cmax,
                                      output int cnt, output bit any,
                                      output int pos);
        logic [6:0] h;
        h = pre;
        cnt = 0;
        any = 0;
        pos = 0;
        for (int i = 0; i < n; i++) begin
            h = {h[5:0], w[n-1-i]};
            if (h == PAT) begin
                if (cnt < cmax) cnt++;
                if (!any) begin
                    any = 1;
                    pos = i;
                end
            end
        end
    endfunction

    typedef struct packed {
        logic busy;
        logic din;
        logic rstn;
        logic done;
    } exp_t;
    localparam exp_t IDLE_E = exp_t'{1'b0, 1'b0, 1'b1, 1'b0};

    exp_t q[$];
    exp_t cur = IDLE_E;
    logic [6:0] mh = '0;
    int p_cnt = 0, p_pos = 0, r_cnt = 0, r_pos = 0;
    bit p_any = 0, r_any = 0;

    // Model: accept starts, build the expected per-cycle output schedule
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            mh = '0;
            q.delete();
        end else begin
            mh = cur.rstn ? {mh[5:0], cur.din} : 7'd0;
            if (ia.start === 1'b1 && !cur.busy) begin
                frame_ref({48'd0, ia.word_in}, 16,
                          ia.clr_mode ? 7'd0 : mh, 255,
                          p_cnt, p_any, p_pos);
                if (ia.clr_mode)
                    q.push_back(exp_t'{1'b1, 1'b0, 1'b0, 1'b0});
                for (int i = 15; i >= 0; i--)
                    q.push_back(exp_t'{1'b1, ia.word_in[i], 1'b1, 1'b0});
                q.push_back(exp_t'{1'b1, 1'b0, 1'b1, 1'b0});
                q.push_back(exp_t'{1'b1, 1'b0, 1'b1, 1'b1});
            end
        end
    end

    // Compare on every falling edge
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            cur = IDLE_E;
            r_cnt = 0;
            r_any = 0;
            r_pos = 0;
            chk("rst_busy", ia.busy, 0);
            chk("rst_done", ia.done, 0);
            chk("rst_det_in", ia.det_in, 0);
            chk("rst_det_rst_n", ia.det_rst_n, 1);
            chk("rst_hit_cnt", ia.hit_cnt, 0);
            chk("rst_hit_any", ia.hit_any, 0);
            chk("rst_first_pos", ia.first_pos, 0);
        end else begin
            if (q.size() != 0) cur = q.pop_front();
            else cur = IDLE_E;
            chk("busy", ia.busy, cur.busy);
            chk("det_in", ia.det_in, cur.din);
            chk("det_rst_n", ia.det_rst_n, cur.rstn);
            chk("done", ia.done, cur.done);
            if (cur.done) begin
                r_cnt = p_cnt;
                r_any = p_any;
                r_pos = p_pos;
            end
            if (cur.done || !cur.busy) begin
                chk("hit_cnt", ia.hit_cnt, r_cnt);
                chk("hit_any", ia.hit_any, r_any);
                chk("first_pos", ia.first_pos, r_pos);
            end
        end
    end

    task automatic run_a(input logic [15:0] w, input logic c,
                         output int lat, output logic [15:0] s,
                         output int nclr);
        int lo;
        lo = c ? 2 : 1;
        @(negedge clk);
        ia.start = 1'b1;
        ia.word_in = w;
        ia.clr_mode = c;
        lat = 0;
        s = '0;
        nclr = 0;
        do begin
            @(negedge clk);
            ia.start = 1'b0;
            lat++;
            if (ia.det_rst_n === 1'b0) nclr++;
            if (lat >= lo && lat < lo + 16) s = {s[14:0], ia.det_in};
        end while (ia.done !== 1'b1 && lat < 60);
        chk("done_reached", ia.done, 1);
    endtask

    int lat, nclr, mc, mp;
    bit ma;
    logic [15:0] s, w16;
    int sh;

    initial begin
        ia.start = 0; ia.word_in = '0; ia.clr_mode = 0;
        ib.start = 0; ib.word_in = '0; ib.clr_mode = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        frame_ref(64'hE400, 16, 7'd0, 255, mc, ma, mp);
        chk("pin_e400_cnt", mc, 1);
        chk("pin_e400_pos", mp, 6);
        frame_ref(64'hE4E4, 16, 7'd0, 255, mc, ma, mp);
        chk("pin_e4e4_cnt", mc, 2);
        chk("pin_e4e4_pos", mp, 6);
        frame_ref(64'hFFFF, 16, 7'd0, 255, mc, ma, mp);
        chk("pin_ffff_any", ma, 0);
        frame_ref(64'hE4E4_0000, 32, 7'd0, 1, mc, ma, mp);
        chk("pin_sat_cnt", mc, 1);

        run_a(16'hE400, 1, lat, s, nclr);
        chk("basic_lat", lat, 19);
        chk("basic_cnt", ia.hit_cnt, 1);
        chk("basic_any", ia.hit_any, 1);
        chk("basic_pos", ia.first_pos, 6);
        chk("basic_stream", s, 16'hE400);
        chk("basic_clr_cycles", nclr, 1);

        run_a(16'hE4E4, 1, lat, s, nclr);
        chk("two_cnt", ia.hit_cnt, 2);
        chk("two_any", ia.hit_any, 1);
        chk("two_pos", ia.first_pos, 6);

        run_a(16'h0000, 0, lat, s, nclr);
        chk("zero_lat", lat, 18);
        chk("zero_cnt", ia.hit_cnt, 0);
        chk("zero_any", ia.hit_any, 0);
        run_a(16'hFFFF, 0, lat, s, nclr);
        chk("ones_lat", lat, 18);
        chk("ones_cnt", ia.hit_cnt, 0);
        chk("ones_pos", ia.first_pos, 0);

        // start during DONE must be dropped
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        chk("done_start_ignored", ia.busy, 0);

        run_a(16'h0007, 0, lat, s, nclr);
        run_a(16'h2000, 0, lat, s, nclr);
        chk("carry_cnt", ia.hit_cnt, p_cnt);
        chk("carry_pos", ia.first_pos, p_pos);
        run_a(16'h0007, 0, lat, s, nclr);
        run_a(16'h2000, 1, lat, s, nclr);
        chk("carry_clr_cnt", ia.hit_cnt, 0);
        chk("carry_clr_rst_cycles", nclr, 1);
        chk("carry_clr_lat", lat, 19);

        @(negedge clk);
        ib.start = 1'b1;
        ib.word_in = 32'hE4E4_0000;
        ib.clr_mode = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            ib.start = (lat == 10);
        end while (ib.done !== 1'b1 && lat < 80);
        ib.start = 1'b0;
        chk("sat_done", ib.done, 1);
        chk("sat_lat", lat, 35);
        chk("sat_cnt", ib.hit_cnt, 1);
        chk("sat_any", ib.hit_any, 1);
        chk("sat_pos", ib.first_pos, 6);

        @(negedge clk);
        ia.start = 1'b1;
        ia.word_in = 16'hE400;
        ia.clr_mode = 1'b0;
        @(negedge clk);
        ia.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", ia.busy, 0);
        chk("arst_det_in", ia.det_in, 0);
        chk("arst_det_rst_n", ia.det_rst_n, 1);
        chk("arst_done", ia.done, 0);
        chk("arst_cnt", ia.hit_cnt, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        run_a(16'hE400, 1, lat, s, nclr);
        chk("post_rst_lat", lat, 19);
        chk("post_rst_cnt", ia.hit_cnt, 1);
        chk("post_rst_pos", ia.first_pos, 6);

        repeat (1500) begin
            @(negedge clk);
            w16 = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                sh = $urandom_range(0, 9);
                w16 = (w16 & ~(16'h007F << sh)) | (16'(PAT) << sh);
            end
            ia.start = ($urandom_range(0, 5) == 0);
            ia.word_in = w16;
            ia.clr_mode = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        ia.start = 1'b0;
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
